scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 141 ++++++++++++++
 tb/tb_scan_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Multiplexed display scan sequencer driving a 74LS138-style address decoder.
// Each enabled digit gets a blanking gap (decoder disabled, address settling)
// followed by an active dwell; disabled digits are skipped circularly.
module scan_sequencer #(
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic [7:0]           MASK,
  output logic                 A0,
  output logic                 A1,
  output logic                 A2,
  output logic                 G1,
  output logic                 G2A,
  output logic                 G2B,
  output logic                 DIGIT_STROBE,
  output logic                 FRAME_DONE
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ACTIVE
  } state_t;

  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

  state_t               state, state_n;
  logic [2:0]           addr, addr_n;
  logic [3:0]           bcnt, bcnt_n;
  logic [DIV_WIDTH-1:0] dcnt, dcnt_n;
  logic                 g1_n, strobe_n, frame_n;

  logic [2:0]           first_idx, next_idx, probe;
  logic                 first_ok, next_ok;

  assign {A2, A1, A0} = addr;

  // State, address, counters and all decoder/strobe outputs are registered here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      addr         <= '0;
      bcnt         <= '0;
      dcnt         <= '0;
      G1           <= 1'b0;
      G2A          <= 1'b1;
      G2B          <= 1'b1;
      DIGIT_STROBE <= 1'b0;
      FRAME_DONE   <= 1'b0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      bcnt         <= bcnt_n;
      dcnt         <= dcnt_n;
      G1           <= g1_n;
      G2A          <= ~g1_n;
      G2B          <= ~g1_n;
      DIGIT_STROBE <= strobe_n;
      FRAME_DONE   <= frame_n;
    end
  end

  // Digit search: lowest set mask bit, and first set bit circularly after the
  // current digit (offset 8 lands back on the current digit itself).
  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (MASK[3'(i - 1)]) begin
        first_idx = 3'(i - 1);
        first_ok  = 1'b1;
      end
    end
    probe    = '0;
    next_idx = '0;
    next_ok  = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      probe = addr + 3'(i);
      if (!next_ok && MASK[probe]) begin
        next_idx = probe;
        next_ok  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    bcnt_n   = bcnt;
    dcnt_n   = dcnt;
    g1_n     = 1'b0;
    strobe_n = 1'b0;
    frame_n  = 1'b0;
    if (!EN) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (first_ok) begin
            state_n = BLANK;
            addr_n  = first_idx;
            bcnt_n  = BLANK_LAST;
          end
        end
        BLANK: begin
          if (bcnt == '0) begin
            state_n  = ACTIVE;
            g1_n     = 1'b1;
            strobe_n = 1'b1;
            dcnt_n   = DIV;
          end else begin
            bcnt_n = bcnt - 4'd1;
          end
        end
        ACTIVE: begin
          if (dcnt == '0) begin
            if (next_ok) begin
              state_n = BLANK;
              addr_n  = next_idx;
              bcnt_n  = BLANK_LAST;
              frame_n = (next_idx <= addr);
            end else begin
              state_n = IDLE;
            end
          end else begin
            g1_n   = 1'b1;
            dcnt_n = dcnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: expected per-cycle output streams
// are generated from the scan rules (digit order, blank/dwell lengths).
module tb_scan_sequencer;
  localparam int DW = 16;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] div = '0;
  logic [7:0]    mask = '0;
  logic          a0, a1, a2, g1, g2a, g2b, ds, fd;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] a;
    logic       g1;
    logic       ds;
    logic       fd;
  } obs_t;

  always #5 clk = ~clk;

  scan_sequencer #(.DIV_WIDTH(DW), .BLANK_CYCLES(BC)) dut (
    .CLK(clk), .RST(rst), .EN(en), .DIV(div), .MASK(mask),
    .A0(a0), .A1(a1), .A2(a2), .G1(g1), .G2A(g2a), .G2B(g2b),
    .DIGIT_STROBE(ds), .FRAME_DONE(fd)
  );

  function automatic obs_t sample();
    return '{a: {a2, a1, a0}, g1: g1, ds: ds, fd: fd};
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_after(input logic [7:0] m, input int cur);
    for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
    return -1;
  endfunction

  // Monitor: enable complementarity, break-before-make, single-cycle pulses.
  logic [2:0] prev_a = '0;
  logic       prev_ds = 1'b0, prev_fd = 1'b0;
  always @(negedge clk) begin
    checks++;
    if (g2a !== ~g1 || g2b !== ~g1) begin
      errors++;
      $display("FAIL enables: g1=%b g2a=%b g2b=%b, required g2a=g2b=~g1", g1, g2a, g2b);
    end
    if (g1 === 1'b1 && {a2, a1, a0} !== prev_a) begin
      errors++;
      $display("FAIL bbm: address %0d while g1=1, required held at %0d", {a2, a1, a0}, prev_a);
    end
    if ((ds && prev_ds) || (fd && prev_fd)) begin
      errors++;
      $display("FAIL pulse: ds=%b fd=%b high two cycles, required single-cycle", ds, fd);
    end
    prev_a  = {a2, a1, a0};
    prev_ds = ds;
    prev_fd = fd;
  end

  task automatic stop_scan();
    @(negedge clk) en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1; en = 1'b1; mask = 8'hFF; div = 16'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== obs_t'(6'b000_000) || g2a !== 1'b1 || g2b !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: got %b g2a=%b g2b=%b, required 000000 1 1", got, g2a, g2b);
      end
    end
    en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== obs_t'(6'b000_000)) begin
        errors++;
        $display("FAIL idle_wait_en: got %b, required 000000", got);
      end
    end
  endtask

  task automatic run_static(input logic [7:0] m, input int d, input int n, input string name);
    obs_t q[$];
    obs_t got;
    int cur, nxt;
    bit wrap = 1'b0;
    cur = lowest(m);
    while (q.size() < n) begin
      for (int b = 0; b < BC; b++)
        q.push_back('{a: 3'(cur), g1: 1'b0, ds: 1'b0, fd: (b == 0) && wrap});
      for (int k = 0; k <= d; k++)
        q.push_back('{a: 3'(cur), g1: 1'b1, ds: (k == 0), fd: 1'b0});
      nxt  = next_after(m, cur);
      wrap = (nxt <= cur);
      cur  = nxt;
    end
    @(negedge clk);
    mask = m; div = DW'(d); en = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== q[k]) begin
        errors++;
        $display("FAIL %s cycle %0d (mask=%h div=%0d): got a/g1/ds/fd=%b required %b",
                 name, k, m, d, got, q[k]);
      end
    end
    stop_scan();
  endtask

  task automatic test_en_drop();
    obs_t got;
    int t = 0;
    @(negedge clk);
    mask = 8'h0E; div = 16'd4; en = 1'b1;
    do begin @(negedge clk); t++; end while (!({a2, a1, a0} == 3'd3 && ds) && t < 200);
    checks++;
    if (!({a2, a1, a0} == 3'd3 && ds)) begin
      errors++;
      $display("FAIL en_drop_wait: digit 3 strobe not seen, addr=%0d ds=%b", {a2, a1, a0}, ds);
    end
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== obs_t'(6'b011_000) || g2a !== 1'b1) begin
        errors++;
        $display("FAIL en_drop_idle: got %b g2a=%b, required 011000 1", got, g2a);
      end
    end
    en = 1'b1;
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== obs_t'(6'b001_000)) begin
      errors++;
      $display("FAIL en_restart_blank: got %b, required 001000", got);
    end
    @(negedge clk);
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== obs_t'(6'b001_110)) begin
      errors++;
      $display("FAIL en_restart_active: got %b, required 001110", got);
    end
    stop_scan();
  endtask

  task automatic test_mask_change();
    obs_t got;
    obs_t exp[$];
    int t = 0;
    @(negedge clk);
    mask = 8'h06; div = 16'd3; en = 1'b1;
    do begin @(negedge clk); t++; end while (!({a2, a1, a0} == 3'd1 && ds) && t < 200);
    checks++;
    if (!({a2, a1, a0} == 3'd1 && ds)) begin
      errors++;
      $display("FAIL mask_wait: digit 1 strobe not seen, addr=%0d ds=%b", {a2, a1, a0}, ds);
    end
    mask = 8'h01;
    // digit 1 finishes its dwell, then wraps to digit 0
    exp = '{6'b001_100, 6'b001_100, 6'b001_100, 6'b000_001, 6'b000_000, 6'b000_110};
    for (int k = 0; k < exp.size(); k++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== exp[k]) begin
        errors++;
        $display("FAIL mask_off_current step %0d: got %b, required %b", k, got, exp[k]);
      end
    end
    mask = 8'h00;
    // digit 0 finishes, then no digit left: idle with no frame pulse
    exp = '{6'b000_100, 6'b000_100, 6'b000_100, 6'b000_000, 6'b000_000, 6'b000_000};
    for (int k = 0; k < exp.size(); k++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== exp[k]) begin
        errors++;
        $display("FAIL mask_zero step %0d: got %b, required %b", k, got, exp[k]);
      end
    end
    stop_scan();
  endtask

  task automatic test_div_hold();
    obs_t got;
    obs_t exp[$];
    int t = 0;
    @(negedge clk);
    mask = 8'h10; div = 16'd4; en = 1'b1;
    do begin @(negedge clk); t++; end while (!ds && t < 200);
    checks++;
    if (!ds) begin
      errors++;
      $display("FAIL div_wait: strobe not seen, ds=%b", ds);
    end
    div = 16'd0;
    exp = '{6'b100_100, 6'b100_100, 6'b100_100, 6'b100_100,
            6'b100_001, 6'b100_000, 6'b100_110, 6'b100_001};
    for (int k = 0; k < exp.size(); k++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== exp[k]) begin
        errors++;
        $display("FAIL div_hold step %0d: got %b, required %b", k, got, exp[k]);
      end
    end
    stop_scan();
  endtask

  task automatic test_async_reset();
    obs_t got;
    int t = 0;
    @(negedge clk);
    mask = 8'hFF; div = 16'd5; en = 1'b1;
    do begin @(negedge clk); t++; end while (!(g1 && {a2, a1, a0} == 3'd2) && t < 200);
    checks++;
    if (!(g1 && {a2, a1, a0} == 3'd2)) begin
      errors++;
      $display("FAIL arst_wait: digit 2 active not seen, g1=%b addr=%0d", g1, {a2, a1, a0});
    end
    #2 rst = 1'b1;
    #1;
    got = sample();
    checks++;
    if (got !== obs_t'(6'b000_000) || g2a !== 1'b1 || g2b !== 1'b1) begin
      errors++;
      $display("FAIL arst_immediate: got %b g2a=%b g2b=%b, required 000000 1 1", got, g2a, g2b);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== obs_t'(6'b000_000)) begin
      errors++;
      $display("FAIL arst_restart_blank: got %b, required 000000", got);
    end
    @(negedge clk);
    @(negedge clk);
    got = sample();
    checks++;
    if (got !== obs_t'(6'b000_110)) begin
      errors++;
      $display("FAIL arst_restart_active: got %b, required 000110", got);
    end
    stop_scan();
  endtask

  task automatic test_random();
    logic [7:0] m;
    int d;
    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom_range(1, 255));
      d = $urandom_range(0, 4);
      run_static(m, d, 48, "random");
    end
  endtask

  initial begin
    test_reset();
    run_static(8'hFF, 3, 51, "full_scan");
    run_static(8'h22, 0, 24, "two_digit");
    run_static(8'h10, 2, 25, "single_digit");
    test_en_drop();
    test_mask_change();
    test_div_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
